// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the snake game item logic.
package snake_pkg;

  localparam int XSIZE    = 48;
  localparam int YSIZE    = 64;
  localparam int MAX_SIZE = 20;
  localparam int DEF_X    = 12;
  localparam int DEF_Y    = 32;
  localparam int COORD_W  = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAW   = 3'd1,
    CHECK  = 3'd2,
    SCAN   = 3'd3,
    REJECT = 3'd4,
    FOUND  = 3'd5
  } spawn_state_t;

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts every clock.
module snake_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  // Shift register with XOR feedback; reset loads the nonzero seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/snake_item_spawner.sv
// Picks a free interior cell for the next food item: random candidates from
// the LFSR, each checked against walls, the current item and every live body
// segment (one per cycle), with a raster sweep fallback after too many misses.
module snake_item_spawner
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 32
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Start,
  input  logic [MAX_SIZE*COORD_W-1:0]   i_Body_x,
  input  logic [MAX_SIZE*COORD_W-1:0]   i_Body_y,
  input  logic [11:0]                   i_Size,
  output logic [COORD_W-1:0]            o_Item_x,
  output logic [COORD_W-1:0]            o_Item_y,
  output logic                          o_Done,
  output logic                          o_Busy
);

  localparam int IDX_W = $clog2(MAX_SIZE + 1);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(XSIZE - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(YSIZE - 1);
  localparam logic [COORD_W-1:0] X_INNER = COORD_W'(XSIZE - 2);
  localparam logic [COORD_W-1:0] Y_INNER = COORD_W'(YSIZE - 2);
  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
  localparam logic [15:0]        TRY_LIM = 16'(MAX_TRIES);
  localparam logic [IDX_W-1:0]   N_MAX   = IDX_W'(MAX_SIZE);

  spawn_state_t state_q, state_d;

  logic [15:0]                 lfsr;
  logic [MAX_SIZE*COORD_W-1:0] body_x_q, body_y_q;
  logic [IDX_W-1:0]            n_q, scan_idx;
  logic [15:0]                 try_q;
  logic                        sweep_q;
  logic [COORD_W-1:0]          sw_x, sw_y;
  logic [COORD_W-1:0]          cand_x, cand_y;
  logic [COORD_W-1:0]          slot_x, slot_y;
  logic                        cand_bad, slot_hit, scan_last;

  snake_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (i_Clk),
    .rst_n (i_Rst),
    .state (lfsr)
  );

  assign slot_x    = body_x_q[int'(scan_idx)*COORD_W +: COORD_W];
  assign slot_y    = body_y_q[int'(scan_idx)*COORD_W +: COORD_W];
  assign slot_hit  = (slot_x == cand_x) && (slot_y == cand_y);
  assign scan_last = (scan_idx == n_q - 1'b1);
  assign cand_bad  = (cand_x == '0) || (cand_x >= X_LAST) ||
                     (cand_y == '0) || (cand_y >= Y_LAST) ||
                     ((cand_x == o_Item_x) && (cand_y == o_Item_y));

  // State register; reset aborts any search in progress.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_Start) state_d = DRAW;
      DRAW:    state_d = CHECK;
      CHECK: begin
        if (cand_bad)        state_d = REJECT;
        else if (n_q == '0)  state_d = FOUND;
        else                 state_d = SCAN;
      end
      SCAN: begin
        if (slot_hit)        state_d = REJECT;
        else if (scan_last)  state_d = FOUND;
      end
      REJECT:  state_d = DRAW;
      FOUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers and published outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_Item_x <= COORD_W'(DEF_X);
      o_Item_y <= COORD_W'(DEF_Y);
      o_Done   <= 1'b1;
      o_Busy   <= 1'b0;
      n_q      <= '0;
      scan_idx <= '0;
      try_q    <= '0;
      sweep_q  <= 1'b0;
      sw_x     <= ONE;
      sw_y     <= ONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_Start) begin
            n_q     <= (i_Size > 12'(MAX_SIZE)) ? N_MAX : i_Size[IDX_W-1:0];
            try_q   <= '0;
            o_Done  <= 1'b0;
            o_Busy  <= 1'b1;
            // With no random tries allowed the sweep begins right away.
            sweep_q <= (TRY_LIM == '0);
            sw_x    <= ONE;
            sw_y    <= ONE;
          end
        end
        CHECK: scan_idx <= '0;
        SCAN: begin
          if (!slot_hit && !scan_last) scan_idx <= scan_idx + 1'b1;
        end
        REJECT: begin
          if (!sweep_q) begin
            try_q <= try_q + 16'd1;
            if (try_q + 16'd1 >= TRY_LIM) begin
              sweep_q <= 1'b1;
              sw_x    <= ONE;
              sw_y    <= ONE;
            end
          end else if (sw_x == X_INNER) begin
            sw_x <= ONE;
            sw_y <= (sw_y == Y_INNER) ? ONE : sw_y + 1'b1;
          end else begin
            sw_x <= sw_x + 1'b1;
          end
        end
        FOUND: begin
          o_Item_x <= cand_x;
          o_Item_y <= cand_y;
          o_Done   <= 1'b1;
          o_Busy   <= 1'b0;
          sweep_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Body snapshot at start and candidate capture in DRAW (data, no reset).
  always_ff @(posedge i_Clk) begin
    if (state_q == IDLE && i_Start) begin
      body_x_q <= i_Body_x;
      body_y_q <= i_Body_y;
    end
    if (state_q == DRAW) begin
      cand_x <= sweep_q ? sw_x : lfsr[5:0];
      cand_y <= sweep_q ? sw_y : lfsr[11:6];
    end
  end

endmodule

// File: tb/tb_snake_item_spawner.sv
// Bench for snake_item_spawner: one random-mode instance and one instance
// that sweeps immediately, checked against a cell-level reference model.
module tb_snake_item_spawner;
  import snake_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_r, start_s;
  logic [MAX_SIZE*COORD_W-1:0] body_x, body_y;
  logic [11:0] size;
  logic [COORD_W-1:0] r_x, r_y, s_x, s_y;
  logic r_done, r_busy, s_done, s_busy;

  int bx[MAX_SIZE];
  int by[MAX_SIZE];

  int n_checks = 0;
  int n_fail   = 0;
  int mr_x, mr_y, ms_x, ms_y;
  int rises_r = 0, rises_s = 0;
  int max_idx = 0;
  logic pr_b = 1'b0, ps_b = 1'b0;

  snake_item_spawner #(.SEED(16'hACE1), .MAX_TRIES(32)) u_rnd (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_r),
    .i_Body_x(body_x), .i_Body_y(body_y), .i_Size(size),
    .o_Item_x(r_x), .o_Item_y(r_y), .o_Done(r_done), .o_Busy(r_busy)
  );

  snake_item_spawner #(.SEED(16'hACE1), .MAX_TRIES(0)) u_swp (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_s),
    .i_Body_x(body_x), .i_Body_y(body_y), .i_Size(size),
    .o_Item_x(s_x), .o_Item_y(s_y), .o_Done(s_done), .o_Busy(s_busy)
  );

  always_comb begin
    body_x = '0;
    body_y = '0;
    for (int k = 0; k < MAX_SIZE; k++) begin
      body_x[k*COORD_W +: COORD_W] = COORD_W'(bx[k]);
      body_y[k*COORD_W +: COORD_W] = COORD_W'(by[k]);
    end
  end

  // Busy pulse counting and scan index high-water mark.
  always @(negedge clk) begin
    if (r_busy && !pr_b) rises_r <= rises_r + 1;
    if (s_busy && !ps_b) rises_s <= rises_s + 1;
    pr_b <= r_busy;
    ps_b <= s_busy;
    if (int'(u_rnd.scan_idx) > max_idx) max_idx <= int'(u_rnd.scan_idx);
    if (int'(u_swp.scan_idx) > max_idx) max_idx <= int'(u_swp.scan_idx);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_n(input int sz);
    return (sz > MAX_SIZE) ? MAX_SIZE : sz;
  endfunction

  function automatic bit in_body(input int x, input int y, input int n);
    for (int i = 0; i < n; i++)
      if (bx[i] == x && by[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // First free interior cell in raster order, excluding item and live body.
  task automatic sweep_expect(input int ix, input int iy, input int n,
                              output int ex, output int ey);
    ex = -1;
    ey = -1;
    for (int y = 1; y <= YSIZE - 2 && ex < 0; y++)
      for (int x = 1; x <= XSIZE - 2 && ex < 0; x++)
        if (!(x == ix && y == iy) && !in_body(x, y, n)) begin
          ex = x;
          ey = y;
        end
  endtask

  // One start pulse; optional second pulse at cycle restart_at.
  task automatic search(input bit sel, input int limit, input int restart_at,
                        output int cycles);
    int base;
    @(negedge clk);
    base = sel ? rises_s : rises_r;
    if (sel) start_s = 1'b1; else start_r = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_r = 1'b0;
    cycles = 1;
    chk("done_falls", sel ? s_done : r_done, 0);
    chk("busy_rises", sel ? s_busy : r_busy, 1);
    while (!(sel ? s_done : r_done) && cycles < limit) begin
      @(posedge clk);
      #1;
      start_s = 1'b0;
      start_r = 1'b0;
      cycles++;
      if (cycles == restart_at) begin
        if (sel) start_s = 1'b1; else start_r = 1'b1;
      end
    end
    start_s = 1'b0;
    start_r = 1'b0;
    chk("done_in_time", sel ? s_done : r_done, 1);
    @(negedge clk);
    @(negedge clk);
    chk("busy_one_pulse", (sel ? rises_s : rises_r) - base, 1);
  endtask

  task automatic verify(input bit sel, input int n);
    int ex, ey, ox, oy;
    if (sel) begin
      ox = int'(s_x);
      oy = int'(s_y);
      sweep_expect(ms_x, ms_y, n, ex, ey);
      chk("sweep_x", ox, ex);
      chk("sweep_y", oy, ey);
      ms_x = ex;
      ms_y = ey;
    end else begin
      ox = int'(r_x);
      oy = int'(r_y);
      chk("rnd_range", (ox >= 1 && ox <= XSIZE - 2 && oy >= 1 &&
                        oy <= YSIZE - 2), 1);
      chk("rnd_not_body", in_body(ox, oy, n), 0);
      chk("rnd_not_prev", (ox == mr_x && oy == mr_y), 0);
      mr_x = ox;
      mr_y = oy;
    end
  endtask

  initial begin
    int cyc;
    int n;
    rst = 1'b0;
    start_r = 1'b0;
    start_s = 1'b0;
    size = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      bx[i] = 40;
      by[i] = 40;
    end
    mr_x = DEF_X; mr_y = DEF_Y; ms_x = DEF_X; ms_y = DEF_Y;

    #12;
    chk("rst_r_x", r_x, DEF_X);
    chk("rst_r_y", r_y, DEF_Y);
    chk("rst_r_done", r_done, 1);
    chk("rst_r_busy", r_busy, 0);
    chk("rst_s_x", s_x, DEF_X);
    chk("rst_s_done", s_done, 1);
    chk("rst_s_busy", s_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Sweep fallback; unused slot 2 holds (3,1) and must be ignored.
    bx[0] = 1; by[0] = 1; bx[1] = 2; by[1] = 1; bx[2] = 3; by[2] = 1;
    size = 12'd2;
    search(1'b1, 500, 0, cyc);
    chk("fallback_x", s_x, 3);
    chk("fallback_y", s_y, 1);
    verify(1'b1, 2);

    // Best-case latency: first sweep cell is free.
    bx[0] = 10; by[0] = 10; bx[1] = 11; by[1] = 10; bx[2] = 12; by[2] = 10;
    bx[3] = 1;  by[3] = 1;
    size = 12'd3;
    search(1'b1, 500, 0, cyc);
    chk("best_latency", cyc, 3 + 4);
    verify(1'b1, 3);

    // Normal random search.
    for (int i = 0; i < 3; i++) begin
      bx[i] = 24;
      by[i] = 32 + i;
    end
    search(1'b0, 32 * 6, 0, cyc);
    verify(1'b0, 3);

    // Size clamp: 20 distinct cells in row 1, length 100.
    for (int i = 0; i < MAX_SIZE; i++) begin
      bx[i] = i + 1;
      by[i] = 1;
    end
    size = 12'd100;
    search(1'b1, 3000, 0, cyc);
    verify(1'b1, MAX_SIZE);
    search(1'b0, 3000, 0, cyc);
    verify(1'b0, MAX_SIZE);

    // Second start three cycles in is ignored.
    for (int i = 0; i < 3; i++) begin
      bx[i] = 24;
      by[i] = 32 + i;
    end
    size = 12'd3;
    search(1'b0, 3000, 3, cyc);
    verify(1'b0, 3);
    repeat (5) begin
      @(negedge clk);
      chk("no_relaunch", r_done, 1);
      chk("item_stable", {r_x, r_y}, {COORD_W'(mr_x), COORD_W'(mr_y)});
    end

    // Abort: reset lands while the sweep instance is scanning 20 slots.
    for (int i = 0; i < MAX_SIZE; i++) begin
      bx[i] = i + 5;
      by[i] = 40;
    end
    size = 12'd20;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_x", s_x, DEF_X);
    chk("abort_y", s_y, DEF_Y);
    chk("abort_done", s_done, 1);
    chk("abort_busy", s_busy, 0);
    chk("abort_r_x", r_x, DEF_X);
    mr_x = DEF_X; mr_y = DEF_Y; ms_x = DEF_X; ms_y = DEF_Y;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    search(1'b1, 3000, 0, cyc);
    chk("fresh_latency", cyc, MAX_SIZE + 4);
    verify(1'b1, MAX_SIZE);

    // Randomized bodies crowded into the top-left corner.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < MAX_SIZE; i++) begin
        bx[i] = $urandom_range(1, 5);
        by[i] = $urandom_range(1, 3);
      end
      size = 12'($urandom_range(0, 26));
      n = eff_n(int'(size));
      search(t[0], 4000, 0, cyc);
      verify(t[0], n);
    end

    chk("scan_idx_max_ok", (max_idx <= MAX_SIZE - 1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_item_spawner.md
Name: snake_item_spawner

Overview:
- Generates the next food-item position for the snake game after each eat event.
- Sits directly upstream of the game-control FSM, which pulses a start request on the first cycle of an eat and waits for a done level before entering SETBODY.
- Draws pseudo-random candidates from a free-running LFSR and scans the snake body one segment per cycle to reject occupied cells.
- Falls back to a linear sweep so that completion is guaranteed.

Parameters:
- XSIZE, 48: field width in cells; border columns 0 and XSIZE-1 are walls.
- YSIZE, 64: field height in cells; border rows 0 and YSIZE-1 are walls.
- MAX_SIZE, 20: number of body slots in the packed body vectors.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- MAX_TRIES, 32: rejected random candidates allowed before switching to sweep mode.
- DEF_X, 12: item x after reset.
- DEF_Y, 32: item y after reset.

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  asynchronous active-low reset
- i_Start  in  1  one-cycle request for a new position
- i_Body_x  in  MAX_SIZE*6  packed body x; slot k at [k*6+:6]; slot 0 is the newest
- i_Body_y  in  MAX_SIZE*6  packed body y, same layout
- i_Size  in  12  current snake length
- o_Item_x  out  6  item x
- o_Item_y  out  6  item y
- o_Done  out  1  level; high when o_Item holds a valid, settled position
- o_Busy  out  1  high while a search is in progress

Behaviour:
- Reset: i_Rst is asynchronous, active-low; clock is i_Clk. Reset values: o_Item_x=DEF_X, o_Item_y=DEF_Y, o_Done=1, o_Busy=0, state=IDLE, LFSR=SEED, try count=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clock in every state.
  - Candidate x = lfsr[5:0], candidate y = lfsr[11:6].
- State IDLE:
  - o_Done=1, o_Busy=0.
  - On i_Start=1: snapshot i_Body_x, i_Body_y, and the effective length N = min(i_Size, MAX_SIZE) into internal registers.
  - Also on i_Start: clear the try count, set o_Done=0 and o_Busy=1 on the next edge, go to DRAW.
- i_Start in any state other than IDLE is ignored; no queueing.
- State DRAW, one cycle:
  - Random mode: latch the LFSR candidate.
  - Sweep mode: latch the sweep candidate.
  - Go to CHECK.
- State CHECK, one cycle, range check. The candidate is rejected if any of these hold:
  - x==0 or x>=XSIZE-1
  - y==0 or y>=YSIZE-1
  - the candidate equals the current o_Item position
- On reject in CHECK: go to REJECT. Otherwise set scan index k=0 and go to SCAN; if N==0, go straight to FOUND.
- State SCAN, one slot per cycle:
  - Compare the candidate with snapshot slot k.
  - Match: go to REJECT.
  - No match and k==N-1: go to FOUND.
  - Otherwise: k=k+1.
- State REJECT:
  - Random mode: try count +1. When try count reaches MAX_TRIES, enter sweep mode with sweep pointer (1,1).
  - Sweep mode: advance x; at x=XSIZE-2, x wraps to 1 and y increments; at y=YSIZE-2 with x wrap, y wraps to 1.
  - Go to DRAW.
- State FOUND, one cycle:
  - o_Item_x/o_Item_y <= candidate, o_Done <= 1, o_Busy <= 0, exit sweep mode, go to IDLE.
- o_Item is updated only in FOUND and holds its value otherwise.
- Latency:
  - Best case: start to o_Done=1 is N+4 cycles.
  - Random-mode worst case is bounded by MAX_TRIES*(N+3).
  - Sweep terminates while any free interior cell exists; this is guaranteed because MAX_SIZE is far smaller than the interior area.
- Body slots with index >= N are never compared.
- MAX_TRIES=0 means sweep mode starts immediately.
- Reset asserted mid-search aborts the search and restores all reset values.

Decomposition:
- Shared package (snake_pkg):
  - XSIZE, YSIZE, MAX_SIZE, DEF_X, DEF_Y
  - coordinate width constant 6
  - state encodings IDLE, DRAW, CHECK, SCAN, REJECT, FOUND
- One sub-module, snake_lfsr16: parameter SEED; ports clk, rst_n, 16-bit state output; free-running.

Test Plan:
- Reset check: assert i_Rst=0 mid-run -> o_Item=(12,32), o_Done=1, o_Busy=0 immediately, asynchronously.
- Normal search: body (24,32),(24,33),(24,34), i_Size=3, pulse i_Start. Required response:
  - o_Done falls on the next cycle.
  - o_Done returns to 1 within MAX_TRIES*6 cycles.
  - Result has 1<=x<=46, 1<=y<=62, is not equal to any body cell, and is not equal to (12,32).
- Sweep fallback: MAX_TRIES=0, body (1,1),(2,1), i_Size=2, o_Item=(12,32) -> o_Item=(3,1) exactly.
- Size clamp: i_Size=100, all 20 slots set to distinct cells in row 1 -> completes; result is not in the 20 slots. A bench counter confirms that index never exceeds 19.
- Ignored start: pulse i_Start again 3 cycles into a search -> exactly one FOUND, o_Item changes once, o_Busy is a single contiguous pulse.
- Abort: assert reset during SCAN, release, pulse i_Start -> a fresh search completes normally; no stale candidate is published.
